tick_sequencer: RTL and testbench
=================================

Name: tick_sequencer

Overview:
- Generates the single-cycle clock-enable strobes for the CPU core and the video pixel pipeline from the one system clock.
- Replaces free-running divided clocks: every downstream block runs on clk_in and is gated by cpu_ce or pix_ce.
- Adds run/halt/single-step sequencing of the CPU enable for the debug front end; video timing never stops.

Parameters:
- CPU_DIV, default 50: system clocks per cpu_ce strobe (100 MHz to 2 MHz); legal range is 2 or more.
- PIX_DIV, default 20: system clocks per pix_ce strobe (100 MHz to 5 MHz); legal range is 1 or more.
- CNT_W, default 32: width of the cpu_cycles counter.

Ports:
- clk_in  in  1  system clock; one clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- run_en  in  1  level; 1 requests free-running CPU.
- halt_req  in  1  level; debug halt request, overrides run_en.
- step  in  1  single-cycle pulse; one CPU tick while halted.
- halt_ack  out  1  1 when state==HALTED.
- cpu_ce  out  1  CPU clock-enable strobe, 1 cycle wide.
- pix_ce  out  1  pixel clock-enable strobe, 1 cycle wide.
- cpu_cycles  out  CNT_W  count of issued cpu_ce pulses.
- state  out  2  HALTED=0, RUN=1, HALTING=2, STEP=3.

Behaviour:
- Reset values (asynchronous, applied immediately mid-operation): state=HALTED, halt_ack=1, cpu_ce=0, pix_ce=0, cpu_cycles=0, both divider counters=0.
- Divider counters:
  - Each counter width is max(1, clog2(DIV)) and counts 0..DIV-1, then wraps to 0.
  - Each strobe is decoded from registers only: cpu_ce = (state in RUN/HALTING/STEP) && cpu_cnt==CPU_DIV-1; pix_ce = pix_run && pix_cnt==PIX_DIV-1.
- pix_run:
  - Cleared by reset; set at the first edge after reset release.
  - PIX_DIV=1 gives pix_ce constant 1 from then on.
  - The pix counter free-runs in every state.
- cpu_cnt holds 0 in HALTED and counts in the other states.
- State transitions:
  - HALTED to RUN: run_en=1 and halt_req=0 sampled at edge k. Consumers see the first cpu_ce=1 at edge k+CPU_DIV, then every CPU_DIV edges after that.
  - HALTED to STEP: step=1 and (run_en=0 or halt_req=1). Exactly one cpu_ce, seen at edge k+CPU_DIV. The state returns to HALTED at that same edge and cpu_cnt resets to 0.
  - HALTED with both the run condition and step: RUN wins and the step is dropped.
  - RUN to HALTING: halt_req=1 or run_en=0. The counter keeps going; the pending cpu_ce still issues. At the edge where the strobe is consumed, the state goes to HALTED and cpu_cnt goes to 0. No partial period is ever truncated.
  - HALTING: cannot be aborted. If run_en and halt_req recover, the block completes to HALTED and then re-enters RUN at the next edge.
- step pulses outside HALTED are ignored (not queued).
- halt_ack is registered state decode; it is 0 throughout STEP.
- cpu_cycles increments on every edge where cpu_ce=1 and wraps from 2^CNT_W-1 to 0.
- cpu_ce and pix_ce may be high in the same cycle; they are fully independent.

Decomposition:
- Package tick_pkg holds:
  - state encodings HALTED/RUN/HALTING/STEP as 2-bit constants;
  - default divider constants CPU_DIV_DEFAULT=50 and PIX_DIV_DEFAULT=20.
- Sub-module ce_counter:
  - Parameters DIV; inputs clk_in, rst_n, clr, en; output strobe.
  - Instantiated twice: the CPU instance has en and clr driven by the FSM; the pixel instance is free-running behind pix_run.
- The FSM and cpu_cycles live in tick_sequencer.

Test Plan:
- Reset release with PIX_DIV=1: first edge after release sets pix_run; pix_ce=1 every cycle after; cpu_ce=0, state=0, halt_ack=1.
- CPU_DIV=4, run_en=1 sampled at edge 10: cpu_ce=1 at edges 14, 18, 22; cpu_cycles=3 after edge 22; halt_ack=0.
- CPU_DIV=4, RUN, halt_req asserted at edge 15: state=HALTING; cpu_ce still at edge 18; state=HALTED and halt_ack=1 after edge 18; no cpu_ce at edge 22.
- HALTED, halt_req=1, step pulse at edge 30: exactly one cpu_ce at edge 34, halt_ack=0 during edges 31-34; a second step at edge 32 is ignored; cpu_cycles increments by 1.
- rst_n dropped mid-RUN with cpu_cnt=2: cpu_ce, pix_ce and cpu_cycles go to 0 immediately without a clock; state=HALTED.
- Wrap check, CNT_W=4: 16 cpu_ce pulses take cpu_cycles 15 to 0; PIX_DIV=3 gives pix_ce every third edge, unaffected by halt/step.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared definitions for the tick sequencer: sequencing states, default
// divider ratios and the divider counter width rule.
package tick_pkg;

    typedef enum logic [1:0] {
        HALTED  = 2'd0,
        RUN     = 2'd1,
        HALTING = 2'd2,
        STEP    = 2'd3
    } tick_state_e;

    localparam int CPU_DIV_DEFAULT = 50;
    localparam int PIX_DIV_DEFAULT = 20;

    // A divide-by-1 counter still needs one bit of storage.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/ce_counter.sv
// Modulo-DIV counter producing a one-cycle strobe on its last count while
// enabled; clr parks it at zero.
module ce_counter
    import tick_pkg::*;
#(
    parameter int DIV = PIX_DIV_DEFAULT
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic strobe
);

    localparam int W = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    // Count 0..DIV-1 and wrap while enabled.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + W'(1);
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign strobe = en && (cnt_q == LAST);

endmodule

// File: rtl/tick_sequencer.sv
// Clock-enable generator for the CPU core and pixel pipeline, with
// run/halt/single-step sequencing of the CPU enable.
module tick_sequencer
    import tick_pkg::*;
#(
    parameter int CPU_DIV = CPU_DIV_DEFAULT,
    parameter int PIX_DIV = PIX_DIV_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             halt_req,
    input  logic             step,
    output logic             halt_ack,
    output logic             cpu_ce,
    output logic             pix_ce,
    output logic [CNT_W-1:0] cpu_cycles,
    output logic [1:0]       state
);

    tick_state_e      state_q;
    logic             halt_ack_q;
    logic             pix_run_q;
    logic [CNT_W-1:0] cpu_cycles_q;

    logic cpu_active_s;
    logic cpu_strobe_s;
    logic pix_strobe_s;
    logic run_ok_s;

    assign cpu_active_s = (state_q != HALTED);
    assign run_ok_s     = run_en && !halt_req;

    ce_counter #(.DIV(CPU_DIV)) u_cpu_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (!cpu_active_s),
        .en     (cpu_active_s),
        .strobe (cpu_strobe_s)
    );

    ce_counter #(.DIV(PIX_DIV)) u_pix_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .en     (pix_run_q),
        .strobe (pix_strobe_s)
    );

    // Pixel timing starts on the first edge after reset and never stops.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pix_run_q <= 1'b0;
        end else begin
            pix_run_q <= 1'b1;
        end
    end

    // Sequencing FSM; a period in flight always completes before HALTED.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HALTED;
            halt_ack_q <= 1'b1;
        end else begin
            case (state_q)
                HALTED: begin
                    if (run_ok_s) begin
                        state_q    <= RUN;
                        halt_ack_q <= 1'b0;
                    end else if (step) begin
                        state_q    <= STEP;
                        halt_ack_q <= 1'b0;
                    end else begin
                        state_q    <= HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run_ok_s && cpu_strobe_s) begin
                        state_q    <= HALTED;
                        halt_ack_q <= 1'b1;
                    end else if (!run_ok_s) begin
                        state_q    <= HALTING;
                        halt_ack_q <= 1'b0;
                    end else begin
                        state_q    <= RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                HALTING, STEP: begin
                    if (cpu_strobe_s) begin
                        state_q    <= HALTED;
                        halt_ack_q <= 1'b1;
                    end else begin
                        state_q    <= state_q;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= HALTED;
                    halt_ack_q <= 1'b1;
                end
            endcase
        end
    end

    // Count every consumed CPU strobe, wrapping naturally.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cycles_q <= '0;
        end else if (cpu_strobe_s) begin
            cpu_cycles_q <= cpu_cycles_q + CNT_W'(1);
        end else begin
            cpu_cycles_q <= cpu_cycles_q;
        end
    end

    assign cpu_ce     = cpu_strobe_s;
    assign pix_ce     = pix_strobe_s;
    assign halt_ack   = halt_ack_q;
    assign cpu_cycles = cpu_cycles_q;
    assign state      = state_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench: two instances (PIX_DIV=1 / PIX_DIV=3 with a 4-bit cycle
// counter) share stimulus; expected values are hand-derived per edge.
module tb_tick_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       run_en;
    logic       halt_req;
    logic       step;

    logic        halt_ack_a, cpu_ce_a, pix_ce_a;
    logic [31:0] cpu_cycles_a;
    logic [1:0]  state_a;
    logic        halt_ack_b, cpu_ce_b, pix_ce_b;
    logic [3:0]  cpu_cycles_b;
    logic [1:0]  state_b;

    int tests = 0;
    int fails = 0;
    int n     = 0;

    always #5 clk_in = ~clk_in;

    tick_sequencer #(.CPU_DIV(4), .PIX_DIV(1), .CNT_W(32)) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .run_en(run_en), .halt_req(halt_req), .step(step),
        .halt_ack(halt_ack_a), .cpu_ce(cpu_ce_a), .pix_ce(pix_ce_a),
        .cpu_cycles(cpu_cycles_a), .state(state_a)
    );

    tick_sequencer #(.CPU_DIV(4), .PIX_DIV(3), .CNT_W(4)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .run_en(run_en), .halt_req(halt_req), .step(step),
        .halt_ack(halt_ack_b), .cpu_ce(cpu_ce_b), .pix_ce(pix_ce_b),
        .cpu_cycles(cpu_cycles_b), .state(state_b)
    );

    task automatic tick();
        @(posedge clk_in);
        n = n + 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run_en = 1'b0; halt_req = 1'b0; step = 1'b0;
        repeat (2) @(posedge clk_in);
        #3;
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a, pix_ce_a, cpu_cycles_a} !== {2'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
            fails++;
            $display("FAIL reset_a: got st=%0d ack=%b ce=%b pix=%b cyc=%0d, want 0 1 0 0 0",
                     state_a, halt_ack_a, cpu_ce_a, pix_ce_a, cpu_cycles_a);
        end
        rst_n = 1'b1;
        n = 0;
        #1;
        tests++;
        if ({pix_ce_a, pix_ce_b} !== 2'b00) begin
            fails++;
            $display("FAIL pix_before_first_edge: got %b%b, want 00", pix_ce_a, pix_ce_b);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            tests++;
            if ({pix_ce_a, pix_ce_b, cpu_ce_a, state_a, halt_ack_a} !==
                {1'b1, ((i % 3) == 0), 1'b0, 2'd0, 1'b1}) begin
                fails++;
                $display("FAIL idle_edge%0d: got pixa=%b pixb=%b ce=%b st=%0d ack=%b, want 1 %b 0 0 1",
                         i, pix_ce_a, pix_ce_b, cpu_ce_a, state_a, halt_ack_a, ((i % 3) == 0));
            end
        end
    endtask

    task automatic test_run();
        run_en = 1'b1;
        tick();
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a} !== {2'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL run_entry: got st=%0d ack=%b ce=%b, want 1 0 0", state_a, halt_ack_a, cpu_ce_a);
        end
        for (int j = 1; j <= 12; j++) begin
            tick();
            tests++;
            if ({cpu_ce_a, cpu_ce_b, pix_ce_b} !== {((j % 4) == 3), ((j % 4) == 3), ((n % 3) == 0)}) begin
                fails++;
                $display("FAIL run_edge%0d: got cea=%b ceb=%b pixb=%b, want %b %b %b", j,
                         cpu_ce_a, cpu_ce_b, pix_ce_b, ((j % 4) == 3), ((j % 4) == 3), ((n % 3) == 0));
            end
        end
        tests++;
        if ({cpu_cycles_a, cpu_cycles_b} !== {32'd3, 4'd3}) begin
            fails++;
            $display("FAIL run_cycles: got %0d/%0d, want 3/3", cpu_cycles_a, cpu_cycles_b);
        end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        tick();
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a} !== {2'd2, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL halting_entry: got st=%0d ack=%b ce=%b, want 2 0 0", state_a, halt_ack_a, cpu_ce_a);
        end
        tick();
        tick();
        tests++;
        if ({state_a, cpu_ce_a, cpu_ce_b} !== {2'd2, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL halting_pending_ce: got st=%0d cea=%b ceb=%b, want 2 1 1", state_a, cpu_ce_a, cpu_ce_b);
        end
        tick();
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a, cpu_cycles_a} !== {2'd0, 1'b1, 1'b0, 32'd4}) begin
            fails++;
            $display("FAIL halted_after_drain: got st=%0d ack=%b ce=%b cyc=%0d, want 0 1 0 4",
                     state_a, halt_ack_a, cpu_ce_a, cpu_cycles_a);
        end
        for (int j = 1; j <= 4; j++) begin
            tick();
            tests++;
            if ({cpu_ce_a, state_b, pix_ce_b} !== {1'b0, 2'd0, ((n % 3) == 0)}) begin
                fails++;
                $display("FAIL halted_quiet%0d: got ce=%b st=%0d pixb=%b, want 0 0 %b",
                         j, cpu_ce_a, state_b, pix_ce_b, ((n % 3) == 0));
            end
        end
    endtask

    task automatic test_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a} !== {2'd3, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL step_entry: got st=%0d ack=%b ce=%b, want 3 0 0", state_a, halt_ack_a, cpu_ce_a);
        end
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a} !== {2'd3, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL step_mid: got st=%0d ack=%b ce=%b, want 3 0 0", state_a, halt_ack_a, cpu_ce_a);
        end
        tick();
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a} !== {2'd3, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL step_ce: got st=%0d ack=%b ce=%b, want 3 0 1", state_a, halt_ack_a, cpu_ce_a);
        end
        tick();
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a, cpu_cycles_a} !== {2'd0, 1'b1, 1'b0, 32'd5}) begin
            fails++;
            $display("FAIL step_done: got st=%0d ack=%b ce=%b cyc=%0d, want 0 1 0 5",
                     state_a, halt_ack_a, cpu_ce_a, cpu_cycles_a);
        end
        for (int j = 1; j <= 5; j++) begin
            tick();
            tests++;
            if ({cpu_ce_a, state_a} !== {1'b0, 2'd0}) begin
                fails++;
                $display("FAIL step_no_second%0d: got ce=%b st=%0d, want 0 0", j, cpu_ce_a, state_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        halt_req = 1'b0;
        step     = 1'b1;
        tick();
        step = 1'b0;
        tests++;
        if (state_a !== 2'd1) begin
            fails++;
            $display("FAIL run_beats_step: got st=%0d, want 1", state_a);
        end
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tests++;
        if (state_a !== 2'd2) begin
            fails++;
            $display("FAIL halt_blip: got st=%0d, want 2", state_a);
        end
        tick();
        tests++;
        if ({state_a, cpu_ce_a} !== {2'd2, 1'b1}) begin
            fails++;
            $display("FAIL halting_no_abort: got st=%0d ce=%b, want 2 1", state_a, cpu_ce_a);
        end
        tick();
        tests++;
        if ({state_a, halt_ack_a, cpu_cycles_a} !== {2'd0, 1'b1, 32'd6}) begin
            fails++;
            $display("FAIL recover_halted: got st=%0d ack=%b cyc=%0d, want 0 1 6", state_a, halt_ack_a, cpu_cycles_a);
        end
        tick();
        tests++;
        if ({state_a, halt_ack_a} !== {2'd1, 1'b0}) begin
            fails++;
            $display("FAIL recover_rerun: got st=%0d ack=%b, want 1 0", state_a, halt_ack_a);
        end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 40; i++) begin
            tick();
            tests++;
            if (pix_ce_b !== ((n % 3) == 0)) begin
                fails++;
                $display("FAIL wrap_pix%0d: got %b, want %b", i, pix_ce_b, ((n % 3) == 0));
            end
            if (i == 36) begin
                tests++;
                if ({cpu_cycles_a, cpu_cycles_b} !== {32'd15, 4'd15}) begin
                    fails++;
                    $display("FAIL wrap_pre: got %0d/%0d, want 15/15", cpu_cycles_a, cpu_cycles_b);
                end
            end
        end
        tests++;
        if ({cpu_cycles_a, cpu_cycles_b} !== {32'd16, 4'd0}) begin
            fails++;
            $display("FAIL wrap_post: got %0d/%0d, want 16/0", cpu_cycles_a, cpu_cycles_b);
        end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        tests++;
        if ({state_a, cpu_ce_a, pix_ce_a} !== {2'd1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL pre_reset: got st=%0d ce=%b pix=%b, want 1 0 1", state_a, cpu_ce_a, pix_ce_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({state_a, halt_ack_a, cpu_ce_a, pix_ce_a, cpu_cycles_a, cpu_cycles_b, state_b} !==
            {2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 2'd0}) begin
            fails++;
            $display("FAIL async_reset: got st=%0d ack=%b ce=%b pix=%b cyca=%0d cycb=%0d stb=%0d, want 0 1 0 0 0 0 0",
                     state_a, halt_ack_a, cpu_ce_a, pix_ce_a, cpu_cycles_a, cpu_cycles_b, state_b);
        end
        #20;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_run();
        test_halt();
        test_step();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
